// File: rtl/z80_bus_arbiter_if.sv
// Bus bundle between the Z80 bus arbiter and its environment: DMA request/grant,
// the Z80 BUSRQ/BUSAK handshake, the CPU and DMA source buses and the muxed pad bus.
interface z80_bus_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        busrq_n;
    logic        busak_n;
    logic [15:0] cpu_A;
    logic [7:0]  cpu_dout;
    logic        cpu_doe;
    logic [3:0]  cpu_ctl;
    logic [31:0] dma_A;
    logic [15:0] dma_dout;
    logic [1:0]  dma_doe;
    logic [7:0]  dma_ctl;
    logic [15:0] bus_A;
    logic [7:0]  bus_dout;
    logic        bus_doe;
    logic [3:0]  bus_ctl;
    logic        owner;
    logic        timeout;

    modport master (
        input  req, busak_n,
        input  cpu_A, cpu_dout, cpu_doe, cpu_ctl,
        input  dma_A, dma_dout, dma_doe, dma_ctl,
        output gnt, busrq_n,
        output bus_A, bus_dout, bus_doe, bus_ctl,
        output owner, timeout
    );

    modport slave (
        output req, busak_n,
        output cpu_A, cpu_dout, cpu_doe, cpu_ctl,
        output dma_A, dma_dout, dma_doe, dma_ctl,
        input  gnt, busrq_n,
        input  bus_A, bus_dout, bus_doe, bus_ctl,
        input  owner, timeout
    );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 external bus between the CPU and two DMA masters via BUSRQ/BUSAK,
// with round-robin ownership, a bounded DMA hold time and a guaranteed CPU gap.
module z80_bus_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int CPU_GAP  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    z80_bus_arbiter_if.master arb
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        GAP     = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CPU_GAP - 1);

    state_t      state_r;
    state_t      state_s;
    logic        owner_r;
    logic        owner_s;
    logic [7:0]  hold_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        own_req_s;
    logic        hold_hit_s;
    logic        busrq_n_r;
    logic        busrq_n_s;
    logic [1:0]  gnt_r;
    logic [1:0]  gnt_s;
    logic        timeout_r;
    logic        timeout_s;
    logic [15:0] bus_a_s;
    logic [7:0]  bus_dout_s;
    logic        bus_doe_s;
    logic [3:0]  bus_ctl_s;

    assign own_req_s  = arb.req[owner_r];
    assign hold_hit_s = (hold_cnt_r == HOLD_LAST);

    // State register, owner latch and the hold/gap cycle counters
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r    <= IDLE;
            owner_r    <= 1'b1;
            hold_cnt_r <= 8'd0;
            gap_cnt_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            if (state_r == GRANT && state_s == GRANT) begin
                hold_cnt_r <= hold_cnt_r + 8'd1;
            end else begin
                hold_cnt_r <= 8'd0;
            end
            if (state_r == GAP && state_s == GAP) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= 8'd0;
            end
        end
    end

    // Next-state and owner selection; a dropped request outranks busak_n in REQ
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        case (state_r)
            IDLE: begin
                if (arb.req != 2'b00) begin
                    state_s = REQ;
                    if (arb.req == 2'b11) begin
                        owner_s = ~owner_r;
                    end else begin
                        owner_s = arb.req[1];
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (!own_req_s) begin
                    state_s = RELEASE;
                end else if (!arb.busak_n) begin
                    state_s = GRANT;
                end else begin
                    state_s = REQ;
                end
            end
            GRANT: begin
                if (!own_req_s || hold_hit_s) begin
                    state_s = RELEASE;
                end else begin
                    state_s = GRANT;
                end
            end
            RELEASE: begin
                if (arb.busak_n) begin
                    state_s = GAP;
                end else begin
                    state_s = RELEASE;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
                owner_s = 1'b1;
            end
        endcase
    end

    // Handshake outputs decoded from the next state so they align with state_r
    always_comb begin
        busrq_n_s = 1'b1;
        gnt_s     = 2'b00;
        timeout_s = 1'b0;
        if (state_s == REQ || state_s == GRANT) begin
            busrq_n_s = 1'b0;
        end else begin
            busrq_n_s = 1'b1;
        end
        if (state_s == GRANT) begin
            gnt_s = owner_r ? 2'b10 : 2'b01;
        end else begin
            gnt_s = 2'b00;
        end
        // A revocation counts as a timeout only while the owner still wanted the bus
        if (state_r == GRANT && hold_hit_s && own_req_s) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Registered handshake outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            busrq_n_r <= 1'b1;
            gnt_r     <= 2'b00;
            timeout_r <= 1'b0;
        end else begin
            busrq_n_r <= busrq_n_s;
            gnt_r     <= gnt_s;
            timeout_r <= timeout_s;
        end
    end

    // Pad bus mux: granted master, else CPU while it owns the bus, else floated
    always_comb begin
        bus_a_s    = 16'h0000;
        bus_dout_s = 8'h00;
        bus_doe_s  = 1'b0;
        bus_ctl_s  = 4'hF;
        if (state_r == GRANT) begin
            if (owner_r) begin
                bus_a_s    = arb.dma_A[31:16];
                bus_dout_s = arb.dma_dout[15:8];
                bus_doe_s  = arb.dma_doe[1];
                bus_ctl_s  = arb.dma_ctl[7:4];
            end else begin
                bus_a_s    = arb.dma_A[15:0];
                bus_dout_s = arb.dma_dout[7:0];
                bus_doe_s  = arb.dma_doe[0];
                bus_ctl_s  = arb.dma_ctl[3:0];
            end
        end else if (arb.busak_n) begin
            bus_a_s    = arb.cpu_A;
            bus_dout_s = arb.cpu_dout;
            bus_doe_s  = arb.cpu_doe;
            bus_ctl_s  = arb.cpu_ctl;
        end else begin
            bus_a_s    = 16'h0000;
            bus_dout_s = 8'h00;
            bus_doe_s  = 1'b0;
            bus_ctl_s  = 4'hF;
        end
    end

    assign arb.busrq_n  = busrq_n_r;
    assign arb.gnt      = gnt_r;
    assign arb.timeout  = timeout_r;
    assign arb.owner    = owner_r;
    assign arb.bus_A    = bus_a_s;
    assign arb.bus_dout = bus_dout_s;
    assign arb.bus_doe  = bus_doe_s;
    assign arb.bus_ctl  = bus_ctl_s;
endmodule
